// File: rtl/uart_pkg.sv
// Shared types and constants for the APB UART transmitter.
// The parity stage is only reachable when APB_UART_PARITY_EN is defined.
package uart_pkg;

    // Frame sequencer states
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    // Register indices, decoded from PADDR[3:2]
    localparam logic [1:0] CTRL   = 2'd0;
    localparam logic [1:0] STATUS = 2'd1;
    localparam logic [1:0] TXDATA = 2'd2;
    localparam logic [1:0] BAUD   = 2'd3;

    // STATUS bit positions
    localparam int ST_FULL   = 0;
    localparam int ST_EMPTY  = 1;
    localparam int ST_BUSY   = 2;
    localparam int ST_OVF    = 3;
    localparam int ST_CNT_LO = 4;
    localparam int ST_CNT_HI = 7;

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous byte FIFO for the UART transmitter.
// A push into a full FIFO is accepted only when a pop happens in the same
// cycle; otherwise the caller is expected to drop the byte.
module uart_tx_fifo #(
    parameter int FIFO_DEPTH = 4,
    localparam int AW = $clog2(FIFO_DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [7:0]    din,
    output logic [7:0]    dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic          do_push;
    logic          do_pop;

    assign full    = (count_reg == CW'(FIFO_DEPTH));
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr_reg];

    // Storage write; no reset so it maps onto plain RAM
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    // Pointers wrap naturally because the depth is a power of two
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/apb_uart_tx.sv
// APB completer wrapping an 8N1 UART transmitter with a small TX FIFO.
// Zero-wait-state: PREADY follows PSEL&PENABLE, PRDATA is combinational.
// Optional odd/even parity bit is built in when APB_UART_PARITY_EN is defined.
module apb_uart_tx
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_RESET  = 867
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic [31:0] PADDR,
    input  logic        PWRITE,
    input  logic        PENABLE,
    input  logic [31:0] PWDATA,
    input  logic        PSEL,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        tx
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          access;
    logic          wr_en;
    logic [1:0]    reg_idx;

    logic          ctrl_en_reg;
`ifdef APB_UART_PARITY_EN
    logic          ctrl_pen_reg;
    logic          ctrl_odd_reg;
    logic          parity_reg;
`endif
    logic [15:0]   baud_div_reg;
    logic          overflow_reg;

    uart_state_e   state_reg;
    logic          tx_reg;
    logic [7:0]    shift_reg;
    logic [2:0]    bit_cnt_reg;
    logic [15:0]   baud_cnt_reg;

    logic          push;
    logic          pop;
    logic [7:0]    fifo_dout;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic          busy;
    logic [2:0]    ctrl_rd;
    logic          unused_ok;

    assign access  = PSEL && PENABLE;
    assign wr_en   = access && PWRITE;
    assign reg_idx = PADDR[3:2];
    assign PREADY  = access;
    assign tx      = tx_reg;
    assign busy    = (state_reg != IDLE);

    assign push = wr_en && (reg_idx == TXDATA);
    assign pop  = (state_reg == IDLE) && ctrl_en_reg && !fifo_empty;

`ifdef APB_UART_PARITY_EN
    assign ctrl_rd = {ctrl_odd_reg, ctrl_pen_reg, ctrl_en_reg};
`else
    assign ctrl_rd = {2'b00, ctrl_en_reg};
`endif

    // Address/data bits the register map never looks at
    assign unused_ok = ^{PADDR[31:4], PADDR[1:0], PWDATA[31:16], fifo_count};

    uart_tx_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk   (PCLK),
        .rst   (PRESET),
        .push  (push),
        .pop   (pop),
        .din   (PWDATA[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Read mux: decoded register while in the access phase, zero otherwise
    always_comb begin
        PRDATA = '0;
        if (access) begin
            case (reg_idx)
                CTRL:   PRDATA[2:0] = ctrl_rd;
                STATUS: begin
                    PRDATA[ST_FULL]             = fifo_full;
                    PRDATA[ST_EMPTY]            = fifo_empty;
                    PRDATA[ST_BUSY]             = busy;
                    PRDATA[ST_OVF]              = overflow_reg;
                    PRDATA[ST_CNT_HI:ST_CNT_LO] = 4'(fifo_count);
                end
                BAUD:   PRDATA[15:0] = baud_div_reg;
                default: PRDATA = '0;
            endcase
        end
    end

    // Control registers and the sticky overflow flag
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            ctrl_en_reg  <= 1'b0;
`ifdef APB_UART_PARITY_EN
            ctrl_pen_reg <= 1'b0;
            ctrl_odd_reg <= 1'b0;
`endif
            baud_div_reg <= 16'(DIV_RESET);
            overflow_reg <= 1'b0;
        end else begin
            if (wr_en && reg_idx == CTRL) begin
                ctrl_en_reg  <= PWDATA[0];
`ifdef APB_UART_PARITY_EN
                ctrl_pen_reg <= PWDATA[1];
                ctrl_odd_reg <= PWDATA[2];
`endif
            end
            if (wr_en && reg_idx == BAUD) begin
                baud_div_reg <= PWDATA[15:0];
            end
            // A pop in the same cycle frees a slot, so only a true overrun sets the flag
            if (push && fifo_full && !pop) begin
                overflow_reg <= 1'b1;
            end else if (wr_en && reg_idx == STATUS && PWDATA[ST_OVF]) begin
                overflow_reg <= 1'b0;
            end
        end
    end

    // Frame sequencer with baud counter; the counter reloads from the live divider at each bit boundary
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_reg    <= IDLE;
            tx_reg       <= 1'b1;
            shift_reg    <= '0;
            bit_cnt_reg  <= '0;
            baud_cnt_reg <= '0;
`ifdef APB_UART_PARITY_EN
            parity_reg   <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    tx_reg <= 1'b1;
                    if (pop) begin
                        state_reg    <= START;
                        tx_reg       <= 1'b0;
                        shift_reg    <= fifo_dout;
                        baud_cnt_reg <= baud_div_reg;
`ifdef APB_UART_PARITY_EN
                        parity_reg   <= ^fifo_dout;
`endif
                    end
                end
                START: begin
                    if (baud_cnt_reg == '0) begin
                        state_reg    <= DATA;
                        tx_reg       <= shift_reg[0];
                        shift_reg    <= {1'b0, shift_reg[7:1]};
                        bit_cnt_reg  <= '0;
                        baud_cnt_reg <= baud_div_reg;
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg - 16'd1;
                    end
                end
                DATA: begin
                    if (baud_cnt_reg == '0) begin
                        baud_cnt_reg <= baud_div_reg;
                        if (bit_cnt_reg == 3'd7) begin
`ifdef APB_UART_PARITY_EN
                            if (ctrl_pen_reg) begin
                                state_reg <= PARITY;
                                tx_reg    <= parity_reg ^ ctrl_odd_reg;
                            end else begin
                                state_reg <= STOP;
                                tx_reg    <= 1'b1;
                            end
`else
                            state_reg <= STOP;
                            tx_reg    <= 1'b1;
`endif
                        end else begin
                            tx_reg      <= shift_reg[0];
                            shift_reg   <= {1'b0, shift_reg[7:1]};
                            bit_cnt_reg <= bit_cnt_reg + 3'd1;
                        end
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg - 16'd1;
                    end
                end
                PARITY: begin
                    if (baud_cnt_reg == '0) begin
                        state_reg    <= STOP;
                        tx_reg       <= 1'b1;
                        baud_cnt_reg <= baud_div_reg;
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg - 16'd1;
                    end
                end
                STOP: begin
                    tx_reg <= 1'b1;
                    if (baud_cnt_reg == '0) begin
                        state_reg <= IDLE;
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg - 16'd1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    tx_reg    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_uart_tx.sv
// Self-checking bench for apb_uart_tx: a frame-level reference model (queue
// of pending bytes, list of line levels still to emit) is compared against
// tx/PREADY every cycle and against every register read.
module tb_apb_uart_tx;

    localparam int DEPTH = 4;
    localparam int DIVR  = 867;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
    logic [31:0] PADDR = '0, PWDATA = '0;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        tx;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    logic [7:0]  mq[$];
    logic        m_bits[$];
    int          m_cyc = 0;
    logic        m_en = 1'b0, m_pen = 1'b0, m_odd = 1'b0, m_ovf = 1'b0;
    logic [15:0] m_div = 16'(DIVR);

    apb_uart_tx #(.FIFO_DEPTH(DEPTH), .DIV_RESET(DIVR)) dut (
        .PCLK(clk), .PRESET(rst), .PADDR(PADDR), .PWRITE(PWRITE), .PENABLE(PENABLE),
        .PWDATA(PWDATA), .PSEL(PSEL), .PRDATA(PRDATA), .PREADY(PREADY), .tx(tx)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: one line level per bit, each held divider+1 cycles; pop before push
    always @(posedge clk or posedge rst) begin : model
        logic [7:0] b;
        if (rst) begin
            mq.delete();
            m_bits.delete();
            m_cyc = 0;
            m_en = 1'b0; m_pen = 1'b0; m_odd = 1'b0; m_ovf = 1'b0;
            m_div = 16'(DIVR);
        end else begin
            if (m_bits.size() != 0) begin
                m_cyc--;
                if (m_cyc == 0) begin
                    void'(m_bits.pop_front());
                    if (m_bits.size() != 0) m_cyc = int'(m_div) + 1;
                end
            end else if (m_en && mq.size() != 0) begin
                b = mq.pop_front();
                m_bits.push_back(1'b0);
                for (int i = 0; i < 8; i++) m_bits.push_back(b[i]);
`ifdef APB_UART_PARITY_EN
                if (m_pen) m_bits.push_back((^b) ^ m_odd);
`endif
                m_bits.push_back(1'b1);
                m_cyc = int'(m_div) + 1;
            end
            if (PSEL && PENABLE && PWRITE) begin
                case (PADDR[3:2])
                    2'd0: begin
                        m_en = PWDATA[0];
`ifdef APB_UART_PARITY_EN
                        m_pen = PWDATA[1];
                        m_odd = PWDATA[2];
`endif
                    end
                    2'd1: if (PWDATA[3]) m_ovf = 1'b0;
                    2'd2: if (mq.size() < DEPTH) mq.push_back(PWDATA[7:0]); else m_ovf = 1'b1;
                    default: m_div = PWDATA[15:0];
                endcase
            end
        end
    end

    function automatic logic [31:0] model_reg(input logic [1:0] a);
        logic busy;
        busy = (m_bits.size() != 0);
        case (a)
            2'd0: return {29'b0, m_odd, m_pen, m_en};
            2'd1: return {24'b0, 4'(mq.size()), m_ovf, busy, mq.size() == 0, mq.size() == DEPTH};
            2'd2: return 32'h0;
            default: return {16'b0, m_div};
        endcase
    endfunction

    // Per-cycle comparison of the serial line and the handshake
    always begin
        @(negedge clk);
        #2;
        if (!rst) begin
            check("tx", {31'b0, tx}, {31'b0, (m_bits.size() != 0) ? m_bits[0] : 1'b1});
            check("pready", {31'b0, PREADY}, {31'b0, PSEL & PENABLE});
        end
    end

    task automatic apb_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = {28'h0, a, 2'b00}; PWDATA = d;
        #1 check("pready_setup", {31'b0, PREADY}, 32'h0);
        @(negedge clk);
        PENABLE = 1'b1;
        #1 check("pready_access", {31'b0, PREADY}, 32'h1);
        @(negedge clk);
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = {28'h0, a, 2'b00};
        #1 check("prdata_setup", PRDATA, 32'h0);
        @(negedge clk);
        PENABLE = 1'b1;
        #1 d = PRDATA;
        check("pready_rd", {31'b0, PREADY}, 32'h1);
        check($sformatf("reg%0d", a), d, model_reg(a));
        @(negedge clk);
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    // Sample one point inside each bit, starting right after a TXDATA write into an idle link
    task automatic sample_frame(input string nm, input logic [10:0] exp_bits, input int nbits, input int per);
        repeat (2) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            if (i > 0) repeat (per) @(negedge clk);
            #1 check($sformatf("%s_bit%0d", nm, i), {31'b0, tx}, {31'b0, exp_bits[i]});
        end
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while ((m_bits.size() != 0 || (m_en && mq.size() != 0)) && k < budget) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (k >= budget) begin
            n_err++;
            $display("FAIL wait_idle: still busy after %0d cycles, required idle", k);
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic [1:0]  rnd_po;

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1 check("rst_tx", {31'b0, tx}, 32'h1);
        apb_read(2'd0, d); check("rst_ctrl", d, 32'h0);
        apb_read(2'd1, d); check("rst_status", d, 32'h2);
        apb_read(2'd2, d); check("rst_txdata", d, 32'h0);
        apb_read(2'd3, d); check("rst_baud", d, 32'd867);

        // 0x55 at 4 cycles per bit
        apb_write(2'd3, 32'd3);
        apb_write(2'd0, 32'h1);
        apb_write(2'd2, 32'h55);
        sample_frame("f55", 11'({1'b1, 8'h55, 1'b0}), 10, 4);
        apb_read(2'd1, d); check("f55_busy", d, 32'h6);
        wait_idle(500);
        apb_read(2'd1, d); check("f55_done", d, 32'h2);

        // Overflow with transmitter disabled, then drain back-to-back
        apb_write(2'd0, 32'h0);
        for (int i = 0; i < 5; i++) apb_write(2'd2, 32'h30 + i);
        apb_read(2'd1, d); check("ovf_status", d, 32'h49);
        apb_write(2'd1, 32'h8);
        apb_read(2'd1, d); check("ovf_clear", d, 32'h41);
        apb_write(2'd0, 32'h1);
        wait_idle(2000);
        apb_read(2'd1, d); check("drain_status", d, 32'h2);

        // EN cleared mid-frame with two bytes queued
        apb_write(2'd3, 32'd1);
        apb_write(2'd2, 32'hA3);
        apb_write(2'd2, 32'h11);
        apb_write(2'd2, 32'h22);
        apb_write(2'd0, 32'h0);
        wait_idle(500);
        apb_read(2'd1, d); check("en_clr_status", d, 32'h20);
        #1 check("en_clr_tx", {31'b0, tx}, 32'h1);

        // Reset in the middle of a data bit that drives the line low
        apb_write(2'd3, 32'd7);
        apb_write(2'd0, 32'h1);
        repeat (30) @(negedge clk);
        #1 check("pre_rst_tx", {31'b0, tx}, 32'h0);
        #2 rst = 1'b1;
        #1 check("mid_rst_tx", {31'b0, tx}, 32'h1);
        @(negedge clk);
        rst = 1'b0;
        apb_read(2'd1, d); check("post_rst_status", d, 32'h2);
        apb_read(2'd3, d); check("post_rst_baud", d, 32'd867);
        apb_read(2'd0, d); check("post_rst_ctrl", d, 32'h0);

`ifdef APB_UART_PARITY_EN
        // Even then odd parity on 0x07 (three ones)
        apb_write(2'd3, 32'd3);
        apb_write(2'd0, 32'h3);
        apb_write(2'd2, 32'h07);
        sample_frame("par_even", {1'b1, 1'b1, 8'h07, 1'b0}, 11, 4);
        wait_idle(500);
        apb_write(2'd0, 32'h7);
        apb_write(2'd2, 32'h07);
        sample_frame("par_odd", {1'b1, 1'b0, 8'h07, 1'b0}, 11, 4);
        wait_idle(500);
        apb_read(2'd0, d); check("par_ctrl", d, 32'h7);
`endif

        // Randomised traffic; parity mode is fixed for the whole run
        rnd_po = 2'b00;
`ifdef APB_UART_PARITY_EN
        rnd_po = 2'($urandom_range(0, 3));
`endif
        apb_write(2'd0, {29'b0, rnd_po, 1'b0});
        for (int it = 0; it < 80; it++) begin
            case ($urandom_range(0, 7))
                0, 1, 2: apb_write(2'd2, $urandom);
                3:       apb_write(2'd0, {29'b0, rnd_po, 1'($urandom_range(0, 1))});
                4:       apb_write(2'd3, {16'($urandom), 16'($urandom_range(0, 4))});
                5:       apb_read(2'($urandom_range(0, 3)), d);
                6:       apb_write(2'd1, $urandom);
                default: repeat ($urandom_range(0, 40)) @(negedge clk);
            endcase
        end
        apb_write(2'd0, {29'b0, rnd_po, 1'b1});
        wait_idle(20000);
        for (int a = 0; a < 4; a++) apb_read(2'(a), d);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
